// File: rtl/alu_bus_pkg.sv
// Shared bus definitions for the integer ALU slave: unit-select codes,
// opcodes and the capture/compute state enum.
package alu_bus_pkg;

  // address[15:12] unit-select codes on the shared data bus
  localparam logic [3:0] MainMemEn    = 4'h0;
  localparam logic [3:0] InstrMemEn   = 4'h1;
  localparam logic [3:0] MatrixMemEn  = 4'h2;
  localparam logic [3:0] ScalarRegEn  = 4'h3;
  localparam logic [3:0] IntegerAluEn = 4'h4;
  localparam logic [3:0] MatrixAluEn  = 4'h5;
  localparam logic [3:0] ExecuteEn    = 4'h6;

  // opcodes broadcast in ExecDataOut[7:0]
  localparam logic [7:0] IntAdd  = 8'h10;
  localparam logic [7:0] IntSub  = 8'h11;
  localparam logic [7:0] IntMult = 8'h12;
  localparam logic [7:0] IntDiv  = 8'h13;
  localparam logic [7:0] Stop    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_OP,
    ST_HAVE_S1,
    ST_HAVE_S2,
    ST_COMPUTE,
    ST_DONE
  } alu_state_e;

endpackage

// File: rtl/int_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first iteration runs on the start edge, so the quotient is ready
// (done=1) DATA_W-1 cycles after start. A zero divisor finishes on the
// start edge with an all-ones quotient and dz=1.
module int_serial_divider
  import alu_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] quotient,
  output logic              done,
  output logic              dz
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;

  logic [DATA_W-1:0] rem_in, quo_in, div_in, rem_nx, quo_nx;
  logic [DATA_W:0]   rem_sh, diff;

  // one restoring step; on start the step works on the fresh operands
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? A  : quo_q;
    div_in = start ? B  : div_q;
    rem_sh = {rem_in, quo_in[DATA_W-1]};
    diff   = rem_sh - {1'b0, div_in};
    quo_nx = {quo_in[DATA_W-2:0], ~diff[DATA_W]};
    rem_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  end

  // iteration registers with a down-counter that stops at terminal count 1
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else if (start) begin
      div_q <= B;
      rem_q <= '0;
      if (B == '0) begin
        quo_q <= '1;
        cnt_q <= '0;
        run_q <= 1'b0;
        done  <= 1'b1;
        dz    <= 1'b1;
      end else begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
        cnt_q <= CNT_W'(DATA_W - 1);
        run_q <= 1'b1;
        done  <= 1'b0;
        dz    <= 1'b0;
      end
    end else if (run_q) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_q <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/integer_alu_unit.sv
// Integer ALU slave on the 256-bit sequencer bus.
//   state      | meaning
//   ST_IDLE    | waiting for an opcode strobe
//   ST_HAVE_OP | opcode latched, waiting for src1
//   ST_HAVE_S1 | src1 latched, waiting for src2
//   ST_HAVE_S2 | src2 latched, waiting for the dest strobe
//   ST_COMPUTE | result being produced (Busy); opcode strobes ignored
//   ST_DONE    | result just committed; falls back to idle
module integer_alu_unit
  import alu_bus_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] UNIT_EN = IntegerAluEn
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [15:0]  address,
  input  logic         nWrite,
  input  logic [255:0] ExecDataOut,
  input  logic         opcodeonBus,
  input  logic         src1onBus,
  input  logic         src2onBus,
  input  logic         destonBus,
  output logic [255:0] AluDataOut,
  output logic         ResultValid,
  output logic         Busy,
  output logic         DivByZero
);

  alu_state_e        state_q, state_d;
  logic [7:0]        opcode_q;
  logic [DATA_W-1:0] a_q, b_q, result_q, result_d;
  logic              valid_q, dz_q;
  logic              sel, st_op, st_s1, st_s2, st_dst;
  logic              cap_op, cap_a, cap_b, div_start, finish;
  logic [DATA_W-1:0] div_quo;
  logic              div_done, div_dz;

  // write-back strobe and unused bus bits are observed only
  logic unused_bits;
  assign unused_bits = ^{nWrite, address[11:0], ExecDataOut[255:DATA_W]};

  // strobe priority opcode > src1 > src2 > dest, qualified by unit select
  assign sel    = (address[15:12] == UNIT_EN);
  assign st_op  = sel & ~opcodeonBus;
  assign st_s1  = sel &  opcodeonBus & ~src1onBus;
  assign st_s2  = sel &  opcodeonBus &  src1onBus & ~src2onBus;
  assign st_dst = sel &  opcodeonBus &  src1onBus &  src2onBus & ~destonBus;

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state and capture controls
  always_comb begin
    state_d   = state_q;
    cap_op    = 1'b0;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    div_start = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (st_op) begin
          cap_op  = 1'b1;
          state_d = ST_HAVE_OP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HAVE_OP: begin
        if (st_op) begin
          cap_op = 1'b1;
        end else if (st_s1) begin
          cap_a   = 1'b1;
          state_d = ST_HAVE_S1;
        end
      end
      ST_HAVE_S1: begin
        if (st_op) begin
          cap_op  = 1'b1;
          state_d = ST_HAVE_OP;
        end else if (st_s2) begin
          cap_b   = 1'b1;
          state_d = ST_HAVE_S2;
        end
      end
      ST_HAVE_S2: begin
        if (st_op) begin
          cap_op  = 1'b1;
          state_d = ST_HAVE_OP;
        end else if (st_dst) begin
          div_start = (opcode_q == IntDiv);
          state_d   = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if ((opcode_q != IntDiv) || div_done) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // single-cycle ops are combinational; unknown opcodes (and Stop) yield 0
  always_comb begin
    result_d = '0;
    case (opcode_q)
      IntAdd:  result_d = a_q + b_q;
      IntSub:  result_d = a_q - b_q;
      IntMult: result_d = a_q * b_q;
      IntDiv:  result_d = div_quo;
      Stop:    result_d = '0;
      default: result_d = '0;
    endcase
  end

  // operand capture and result/flag registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      if (cap_op) begin
        opcode_q <= ExecDataOut[7:0];
        result_q <= '0;
        valid_q  <= 1'b0;
        dz_q     <= 1'b0;
      end
      if (cap_a) a_q <= ExecDataOut[DATA_W-1:0];
      if (cap_b) b_q <= ExecDataOut[DATA_W-1:0];
      if (finish) begin
        result_q <= result_d;
        valid_q  <= 1'b1;
        if (opcode_q == IntDiv) dz_q <= div_dz;
      end
    end
  end

  int_serial_divider #(.DATA_W(DATA_W)) u_div (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (div_start),
    .A        (a_q),
    .B        (b_q),
    .quotient (div_quo),
    .done     (div_done),
    .dz       (div_dz)
  );

  assign AluDataOut  = {{(256-DATA_W){1'b0}}, result_q};
  assign ResultValid = valid_q;
  assign Busy        = (state_q == ST_COMPUTE);
  assign DivByZero   = dz_q;

endmodule

// File: tb/tb_integer_alu_unit.sv
`timescale 1ns/1ps
module tb_integer_alu_unit;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [15:0]  address;
  logic         nWrite;
  logic [255:0] ExecDataOut;
  logic         opcodeonBus, src1onBus, src2onBus, destonBus;
  logic [255:0] AluDataOut;
  logic         ResultValid, Busy, DivByZero;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model: protocol progress plus the arithmetic answer and its latency
  int          m_stage;   // 0 waiting opcode, 1 want src1, 2 want src2, 3 want dest, 4 computing
  int          m_wait;
  logic [7:0]  m_op;
  logic [31:0] m_a, m_b, m_res, m_pend;
  logic        m_valid, m_dz, m_pdz;

  integer_alu_unit #(.DATA_W(32), .UNIT_EN(4'd4)) dut (
    .Clk(Clk), .Reset(Reset), .address(address), .nWrite(nWrite),
    .ExecDataOut(ExecDataOut), .opcodeonBus(opcodeonBus), .src1onBus(src1onBus),
    .src2onBus(src2onBus), .destonBus(destonBus), .AluDataOut(AluDataOut),
    .ResultValid(ResultValid), .Busy(Busy), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_wait = 0; m_op = '0; m_a = '0; m_b = '0;
    m_res = '0; m_pend = '0; m_valid = 1'b0; m_dz = 1'b0; m_pdz = 1'b0;
  endtask

  task automatic model_step();
    int win;
    if (Reset) begin
      model_reset();
      return;
    end
    if (m_stage == 4) begin
      m_wait--;
      if (m_wait == 0) begin
        m_stage = 0;
        m_valid = 1'b1;
        m_res   = m_pend;
        if (m_pdz) m_dz = 1'b1;
      end
      return;
    end
    if (address[15:12] != 4'd4) return;
    win = !opcodeonBus ? 0 : !src1onBus ? 1 : !src2onBus ? 2 : !destonBus ? 3 : -1;
    if (win == 0) begin
      m_op = ExecDataOut[7:0]; m_res = '0; m_valid = 1'b0; m_dz = 1'b0; m_stage = 1;
    end else if (win == 1 && m_stage == 1) begin
      m_a = ExecDataOut[31:0]; m_stage = 2;
    end else if (win == 2 && m_stage == 2) begin
      m_b = ExecDataOut[31:0]; m_stage = 3;
    end else if (win == 3 && m_stage == 3) begin
      m_pdz = 1'b0;
      m_wait = 1;
      case (m_op)
        8'h10: m_pend = m_a + m_b;
        8'h11: m_pend = m_a - m_b;
        8'h12: m_pend = m_a * m_b;
        8'h13: begin
          if (m_b == 0) begin
            m_pend = 32'hFFFF_FFFF;
            m_pdz  = 1'b1;
          end else begin
            m_pend = m_a / m_b;
            m_wait = 32;
          end
        end
        default: m_pend = '0;
      endcase
      m_stage = 4;
    end
  endtask

  // compare DUT against the model on every falling edge
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy",  256'(Busy),        256'(m_stage == 4));
      check("valid", 256'(ResultValid), 256'(m_valid));
      check("data",  AluDataOut,        256'(m_res));
      check("dz",    256'(DivByZero),   256'(m_dz));
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 8'h10;
      1: return 8'h11;
      2: return 8'h12;
      3: return 8'h13;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    address = 16'h0000; nWrite = 1'b1; ExecDataOut = '0;
    opcodeonBus = 1'b1; src1onBus = 1'b1; src2onBus = 1'b1; destonBus = 1'b1;
  endtask

  // one strobe cycle: which 0=opcode 1=src1 2=src2 3=dest
  task automatic strobe(input logic [3:0] unit, input int which, input logic [31:0] data);
    logic [255:0] w;
    w = rand256();
    w[31:0] = data;
    address = {unit, 12'($urandom)};
    ExecDataOut = w;
    nWrite = 1'($urandom);
    opcodeonBus = (which != 0);
    src1onBus   = (which != 1);
    src2onBus   = (which != 2);
    destonBus   = (which != 3);
    tick();
    drive_idle();
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc);
    strobe(4'd4, 0, {24'h0, op});
    strobe(4'd4, 1, a);
    strobe(4'd4, 2, b);
    strobe(4'd4, 3, 32'h0);
    busy_cyc = 0;
    while (Busy && busy_cyc < 100) begin
      busy_cyc++;
      tick();
    end
  endtask

  initial begin
    int bc;
    drive_idle();
    Reset = 1'b1;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
    check("reset_data",  AluDataOut,        256'h0);
    check("reset_valid", 256'(ResultValid), 256'h0);
    check("reset_busy",  256'(Busy),        256'h0);
    check("reset_dz",    256'(DivByZero),   256'h0);
    chk_en = 1'b1;

    // add: dest edge -> Busy, next edge -> result
    strobe(4'd4, 0, 32'h10);
    strobe(4'd4, 1, 32'd7);
    strobe(4'd4, 2, 32'd5);
    strobe(4'd4, 3, 32'd0);
    check("add_busy",  256'(Busy),        256'h1);
    check("add_early", 256'(ResultValid), 256'h0);
    tick();
    check("add_valid", 256'(ResultValid), 256'h1);
    check("add_data",  AluDataOut,        256'd12);

    // matrix-unit traffic must not disturb the held result
    strobe(4'd5, 0, 32'h11);
    strobe(4'd5, 1, 32'd1);
    strobe(4'd5, 2, 32'd1);
    strobe(4'd5, 3, 32'd0);
    tick();
    check("matrix_valid", 256'(ResultValid), 256'h1);
    check("matrix_data",  AluDataOut,        256'd12);
    check("matrix_busy",  256'(Busy),        256'h0);

    run_op(8'h11, 32'd3, 32'd5, bc);
    check("sub_data", AluDataOut, 256'h0000_0000_FFFF_FFFE);
    check("sub_busy_cycles", 256'(bc), 256'd1);

    run_op(8'h12, 32'h0001_0000, 32'h0001_0000, bc);
    check("mul_wrap", AluDataOut, 256'h0);

    run_op(8'h13, 32'd100, 32'd7, bc);
    check("div_busy_cycles", 256'(bc), 256'd32);
    check("div_data", AluDataOut, 256'd14);

    run_op(8'h13, 32'd55, 32'd0, bc);
    check("div0_data", AluDataOut, 256'hFFFF_FFFF);
    check("div0_dz",   256'(DivByZero), 256'h1);
    strobe(4'd4, 0, 32'h10);
    check("dz_cleared",    256'(DivByZero),   256'h0);
    check("valid_cleared", 256'(ResultValid), 256'h0);
    check("data_cleared",  AluDataOut,        256'h0);

    // re-sync: new opcode while waiting for src2
    strobe(4'd4, 1, 32'd9);
    strobe(4'd4, 0, 32'h11);
    strobe(4'd4, 1, 32'd20);
    strobe(4'd4, 2, 32'd6);
    strobe(4'd4, 3, 32'd0);
    tick();
    check("resync_data", AluDataOut, 256'd14);

    // reset in the middle of a division
    strobe(4'd4, 0, 32'h13);
    strobe(4'd4, 1, 32'd1000);
    strobe(4'd4, 2, 32'd3);
    strobe(4'd4, 3, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("middiv_busy", 256'(Busy), 256'h1);
    Reset = 1'b1;
    model_reset();
    #1;
    check("rst_data",  AluDataOut,        256'h0);
    check("rst_valid", 256'(ResultValid), 256'h0);
    check("rst_busy",  256'(Busy),        256'h0);
    check("rst_dz",    256'(DivByZero),   256'h0);
    tick();
    Reset = 1'b0;
    run_op(8'h10, 32'hFFFF_FFFF, 32'd2, bc);
    check("post_rst_add", AluDataOut, 256'd1);

    // randomized traffic, mostly advancing the handshake
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_idle();
      address = {(($urandom_range(0, 99) < 85) ? 4'd4 : 4'($urandom_range(0, 15))), 12'($urandom)};
      nWrite = 1'($urandom);
      ExecDataOut = rand256();
      if (m_stage <= 3 && $urandom_range(0, 9) < 7) begin
        case (m_stage)
          0:       opcodeonBus = 1'b0;
          1:       src1onBus   = 1'b0;
          2:       src2onBus   = 1'b0;
          default: destonBus   = 1'b0;
        endcase
      end else begin
        opcodeonBus = ($urandom_range(0, 99) >= 4);
        src1onBus   = ($urandom_range(0, 99) >= 15);
        src2onBus   = ($urandom_range(0, 99) >= 15);
        destonBus   = ($urandom_range(0, 99) >= 15);
      end
      if (!opcodeonBus) ExecDataOut[7:0] = pick_op();
      else if ($urandom_range(0, 9) < 2) ExecDataOut[31:0] = 32'h0;
      else if ($urandom_range(0, 9) < 3) ExecDataOut[31:0] = 32'($urandom_range(0, 300));
      tick();
    end
    drive_idle();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
